// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
// The request struct widths match the arbiter's default ADDR_WIDTH/DATA_WIDTH.
package memory_arbiter_pkg;

    localparam int unsigned PORT_LOADER    = 0;
    localparam int unsigned PORT_UNLOADER  = 1;
    localparam int unsigned PORT_CORE      = 2;

    localparam int unsigned REQ_ADDR_WIDTH = 28;
    localparam int unsigned REQ_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_READ
    } arb_state_t;

    typedef struct packed {
        logic                      write;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first pending port after i_last_grant, wrapping.
module rr_picker #(
    parameter int unsigned NUM_PORTS = 3,
    localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] i_pending,
    input  logic [IdxW-1:0]      i_last_grant,
    output logic                 o_grant_valid,
    output logic [IdxW-1:0]      o_grant_idx
);

    int unsigned w_cand;

    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        w_cand        = 0;
        for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
            w_cand = 32'(i_last_grant) + off;
            if (w_cand >= NUM_PORTS) begin
                w_cand = w_cand - NUM_PORTS;
            end
            if (!o_grant_valid && i_pending[IdxW'(w_cand)]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = IdxW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_PORTS pulse-driven requesters,
// with one transaction outstanding and per-port held read data.
module memory_port_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned ADDR_WIDTH = 28,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                            clk_memory,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req_en,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            port_busy,
    output logic [NUM_PORTS-1:0]            port_done,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] port_rdata,
    output logic [NUM_PORTS-1:0]            port_overflow,
    output logic                            mem_req,
    output logic                            mem_write,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic                            mem_ack,
    input  logic                            mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    localparam int unsigned     IdxW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_PORTS - 1);

    arb_state_t                      r_state;
    mem_req_t                        r_req [NUM_PORTS];
    logic [NUM_PORTS-1:0]            r_pending;
    logic [NUM_PORTS-1:0]            r_busy;
    logic [NUM_PORTS-1:0]            r_done;
    logic [NUM_PORTS-1:0]            r_overflow;
    logic [NUM_PORTS*DATA_WIDTH-1:0] r_rdata;
    logic [IdxW-1:0]                 r_grant;
    logic [IdxW-1:0]                 r_last_grant;
    logic                            r_mem_req;
    logic                            r_mem_write;
    logic [ADDR_WIDTH-1:0]           r_mem_addr;
    logic [DATA_WIDTH-1:0]           r_mem_wdata;

    logic [NUM_PORTS-1:0]            w_accept;
    logic                            w_grant_valid;
    logic [IdxW-1:0]                 w_grant_idx;

    // A pulse in a port's done cycle reuses the port immediately.
    always_comb w_accept = req_en & (~r_busy | r_done);

    rr_picker #(
        .NUM_PORTS(NUM_PORTS)
    ) u_rr_picker (
        .i_pending    (r_pending),
        .i_last_grant (r_last_grant),
        .o_grant_valid(w_grant_valid),
        .o_grant_idx  (w_grant_idx)
    );

    always_ff @(posedge clk_memory) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pending    <= '0;
            r_busy       <= '0;
            r_done       <= '0;
            r_overflow   <= '0;
            r_rdata      <= '0;
            r_grant      <= '0;
            r_last_grant <= LastIdx;
            r_mem_req    <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_req[i] <= '0;
            end
        end else begin
            r_done <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_accept[i]) begin
                    r_req[i].write <= req_write[i];
                    r_req[i].addr  <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    r_req[i].wdata <= req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    r_pending[i]   <= 1'b1;
                    r_busy[i]      <= 1'b1;
                end else if (req_en[i]) begin
                    r_overflow[i] <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_grant                <= w_grant_idx;
                        r_last_grant           <= w_grant_idx;
                        r_pending[w_grant_idx] <= 1'b0;
                        r_mem_req              <= 1'b1;
                        r_mem_write            <= r_req[w_grant_idx].write;
                        r_mem_addr             <= r_req[w_grant_idx].addr;
                        r_mem_wdata            <= r_req[w_grant_idx].wdata;
                        r_state                <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        // Reads whose data arrives with the ack skip WAIT_READ.
                        if (r_mem_write || mem_rdata_valid) begin
                            if (!r_mem_write) begin
                                r_rdata[r_grant*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                            end
                            r_done[r_grant] <= 1'b1;
                            r_busy[r_grant] <= 1'b0;
                            r_state         <= IDLE;
                        end else begin
                            r_state <= WAIT_READ;
                        end
                    end
                end
                WAIT_READ: begin
                    if (mem_rdata_valid) begin
                        r_rdata[r_grant*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                        r_done[r_grant] <= 1'b1;
                        r_busy[r_grant] <= 1'b0;
                        r_state         <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign port_busy     = r_busy;
    assign port_done     = r_done;
    assign port_rdata    = r_rdata;
    assign port_overflow = r_overflow;
    assign mem_req       = r_mem_req;
    assign mem_write     = r_mem_write;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed self-checking bench for memory_port_arbiter.
module tb_memory_port_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 28;
    localparam int unsigned DW = 16;

    logic              clk_memory = 1'b0;
    logic              reset;
    logic [N-1:0]      req_en;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      port_busy;
    logic [N-1:0]      port_done;
    logic [N*DW-1:0]   port_rdata;
    logic [N-1:0]      port_overflow;
    logic              mem_req;
    logic              mem_write;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ack;
    logic              mem_rdata_valid;
    logic [DW-1:0]     mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          done_cnt [N];
    int          done_order[$];
    logic [AW-1:0] grant_addr[$];
    logic        grant_write[$];
    logic [DW-1:0] grant_wdata[$];
    logic        prev_req;

    always #5 clk_memory = ~clk_memory;

    memory_port_arbiter #(
        .NUM_PORTS (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk_memory     (clk_memory),
        .reset          (reset),
        .req_en         (req_en),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .port_busy      (port_busy),
        .port_done      (port_done),
        .port_rdata     (port_rdata),
        .port_overflow  (port_overflow),
        .mem_req        (mem_req),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata_valid(mem_rdata_valid),
        .mem_rdata      (mem_rdata)
    );

    // Advance one clock and log memory grants and done pulses seen after the edge.
    task automatic step();
        @(posedge clk_memory);
        #1;
        cyc++;
        if (mem_req === 1'b1 && prev_req !== 1'b1) begin
            grant_addr.push_back(mem_addr);
            grant_write.push_back(mem_write);
            grant_wdata.push_back(mem_wdata);
        end
        prev_req = mem_req;
        for (int i = 0; i < N; i++) begin
            if (port_done[i] === 1'b1) begin
                done_cnt[i]++;
                done_order.push_back(i);
            end
        end
    endtask

    task automatic clear_log();
        grant_addr.delete();
        grant_write.delete();
        grant_wdata.delete();
        done_order.delete();
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        prev_req = mem_req;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        clear_log();
    endtask

    task automatic set_req(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_write[p]         = w;
        req_addr[p*AW +: AW] = a;
        req_wdata[p*DW +: DW] = d;
    endtask

    task automatic fire(input logic [N-1:0] mask);
        req_en = mask;
        step();
        req_en = '0;
    endtask

    // Memory responder: ack after ack_delay idle cycles; read data data_delay cycles after ack.
    task automatic serve(input int ack_delay, input int data_delay, input logic [DW-1:0] data);
        logic is_write;
        int   guard;
        guard = 0;
        while (mem_req !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        if (mem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL serve_wait: mem_req=%b after %0d cycles, required 1", mem_req, guard);
            return;
        end
        is_write = mem_write;
        repeat (ack_delay) step();
        mem_ack = 1'b1;
        if (!is_write && data_delay == 0) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = data;
        end
        step();
        mem_ack         = 1'b0;
        mem_rdata_valid = 1'b0;
        if (is_write || data_delay == 0) return;
        repeat (data_delay - 1) step();
        mem_rdata_valid = 1'b1;
        mem_rdata       = data;
        step();
        mem_rdata_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (port_busy !== 3'b000 || port_done !== 3'b000 || port_overflow !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b ovf=%b, required 000 000 000",
                     port_busy, port_done, port_overflow);
        end
        checks++;
        if (mem_req !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_mem: req=%b wr=%b addr=%h wdata=%h, required all 0",
                     mem_req, mem_write, mem_addr, mem_wdata);
        end
        checks++;
        if (port_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h, required 0", port_rdata);
        end
        reset = 1'b0;
        clear_log();
    endtask

    task automatic test_single_read();
        apply_reset();
        set_req(1, 1'b0, 28'hC, 16'h0);
        fire(3'b010);
        checks++;
        if (port_busy !== 3'b010 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL read_capture: busy=%b mem_req=%b, required 010 0", port_busy, mem_req);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 28'hC || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL read_issue: req=%b addr=%h wr=%b, required 1 000000c 0",
                     mem_req, mem_addr, mem_write);
        end
        serve(1, 2, 16'hAABB);
        checks++;
        if (port_done !== 3'b010 || port_rdata[DW +: DW] !== 16'hAABB || port_busy !== 3'b000) begin
            errors++;
            $display("FAIL read_done: done=%b rdata1=%h busy=%b, required 010 aabb 000",
                     port_done, port_rdata[DW +: DW], port_busy);
        end
        step();
        step();
        checks++;
        if (done_cnt[1] !== 1 || port_rdata[DW +: DW] !== 16'hAABB) begin
            errors++;
            $display("FAIL read_once: done pulses=%0d rdata1=%h, required 1 aabb",
                     done_cnt[1], port_rdata[DW +: DW]);
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] exp_addr [3];
        bit            order_ok;
        exp_addr = '{28'h10, 28'hE, 28'h124};
        apply_reset();
        set_req(0, 1'b1, 28'h10, 16'h1234);
        set_req(1, 1'b0, 28'hE, 16'h0);
        set_req(2, 1'b0, 28'h124, 16'h0);
        fire(3'b111);
        checks++;
        if (port_busy !== 3'b111) begin
            errors++;
            $display("FAIL cont_busy: got %b, required 111", port_busy);
        end
        serve(0, 1, 16'h0);
        checks++;
        if (mem_req !== 1'b0 || port_done !== 3'b001) begin
            errors++;
            $display("FAIL cont_write_done: mem_req=%b done=%b, required 0 001", mem_req, port_done);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 28'hE) begin
            errors++;
            $display("FAIL cont_gap: mem_req=%b addr=%h, required 1 000000e", mem_req, mem_addr);
        end
        serve(0, 1, 16'h1111);
        serve(0, 1, 16'h2222);
        step();
        order_ok = (grant_addr.size() == 3) && (done_order.size() == 3);
        for (int i = 0; i < 3 && order_ok; i++) begin
            if (grant_addr[i] !== exp_addr[i] || done_order[i] != i) order_ok = 1'b0;
        end
        checks++;
        if (!order_ok) begin
            errors++;
            $display("FAIL cont_order: grants=%p dones=%p, required addr 10,e,124 ports 0,1,2",
                     grant_addr, done_order);
        end
        checks++;
        if (grant_write.size() < 1 || grant_write[0] !== 1'b1 || grant_wdata[0] !== 16'h1234) begin
            errors++;
            $display("FAIL cont_wdata: write=%p wdata=%p, required first 1 1234",
                     grant_write, grant_wdata);
        end
        checks++;
        if (port_rdata !== {16'h2222, 16'h1111, 16'h0000}) begin
            errors++;
            $display("FAIL cont_rdata: got %h, required 222211110000", port_rdata);
        end
    endtask

    task automatic test_rr_wrap();
        clear_log();
        set_req(0, 1'b1, 28'h20, 16'hA0A0);
        set_req(2, 1'b1, 28'h30, 16'hB0B0);
        fire(3'b101);
        serve(0, 0, 16'h0);
        serve(0, 0, 16'h0);
        step();
        checks++;
        if (grant_addr.size() != 2 || grant_addr[0] !== 28'h20 || grant_addr[1] !== 28'h30) begin
            errors++;
            $display("FAIL rr_wrap: grants=%p, required 20,30", grant_addr);
        end
        checks++;
        if (done_order.size() != 2 || done_order[0] != 0 || done_order[1] != 2) begin
            errors++;
            $display("FAIL rr_done: dones=%p, required 0,2", done_order);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        set_req(1, 1'b0, 28'h40, 16'h0);
        fire(3'b010);
        serve(0, 1, 16'h5555);
        checks++;
        if (port_done !== 3'b010 || port_rdata[DW +: DW] !== 16'h5555) begin
            errors++;
            $display("FAIL b2b_first: done=%b rdata1=%h, required 010 5555",
                     port_done, port_rdata[DW +: DW]);
        end
        set_req(1, 1'b0, 28'h44, 16'h0);
        fire(3'b010);
        checks++;
        if (port_busy !== 3'b010 || port_overflow !== 3'b000) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b ovf=%b, required 010 000", port_busy, port_overflow);
        end
        serve(0, 1, 16'h6666);
        checks++;
        if (grant_addr.size() != 2 || grant_addr[1] !== 28'h44 ||
            port_rdata[DW +: DW] !== 16'h6666) begin
            errors++;
            $display("FAIL b2b_second: grants=%p rdata1=%h, required 40,44 6666",
                     grant_addr, port_rdata[DW +: DW]);
        end
    endtask

    task automatic test_overflow();
        // Entered in port 1's done cycle from the back-to-back scenario.
        set_req(1, 1'b0, 28'h48, 16'h0);
        fire(3'b010);
        set_req(1, 1'b0, 28'h4C, 16'h0);
        fire(3'b010);
        checks++;
        if (port_overflow !== 3'b010) begin
            errors++;
            $display("FAIL ovf_set: got %b, required 010", port_overflow);
        end
        serve(0, 1, 16'h7777);
        repeat (4) step();
        checks++;
        if (grant_addr.size() != 3 || grant_addr[2] !== 28'h48 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drop: grants=%p mem_req=%b, required 40,44,48 0",
                     grant_addr, mem_req);
        end
        checks++;
        if (port_overflow !== 3'b010 || port_busy !== 3'b000) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b busy=%b, required 010 000", port_overflow, port_busy);
        end
    endtask

    task automatic test_ack_valid_same();
        int c0;
        apply_reset();
        set_req(1, 1'b0, 28'h126, 16'h0);
        fire(3'b010);
        c0 = cyc;
        serve(0, 0, 16'hDDCC);
        checks++;
        if (port_done !== 3'b010 || port_rdata[DW +: DW] !== 16'hDDCC || cyc - c0 != 2) begin
            errors++;
            $display("FAIL ackvalid_done: done=%b rdata1=%h cycles=%0d, required 010 ddcc 2",
                     port_done, port_rdata[DW +: DW], cyc - c0);
        end
        step();
        checks++;
        if (mem_req !== 1'b0 || port_busy !== 3'b000 || done_cnt[1] != 1) begin
            errors++;
            $display("FAIL ackvalid_idle: mem_req=%b busy=%b pulses=%0d, required 0 000 1",
                     mem_req, port_busy, done_cnt[1]);
        end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        set_req(1, 1'b0, 28'h200, 16'h0);
        fire(3'b010);
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || port_busy !== 3'b010) begin
            errors++;
            $display("FAIL midrd_wait: mem_req=%b busy=%b, required 0 010", mem_req, port_busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_rdata_valid = 1'b1;
        mem_rdata       = 16'hBEEF;
        step();
        mem_rdata_valid = 1'b0;
        step();
        checks++;
        if (done_cnt[1] != 0 || port_rdata !== '0 || port_busy !== 3'b000) begin
            errors++;
            $display("FAIL midrd_discard: pulses=%0d rdata=%h busy=%b, required 0 0 000",
                     done_cnt[1], port_rdata, port_busy);
        end
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== '0 || port_overflow !== 3'b000) begin
            errors++;
            $display("FAIL midrd_state: mem_req=%b addr=%h ovf=%b, required 0 0 000",
                     mem_req, mem_addr, port_overflow);
        end
    endtask

    initial begin
        reset           = 1'b1;
        req_en          = '0;
        req_write       = '0;
        req_addr        = '0;
        req_wdata       = '0;
        mem_ack         = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_rdata       = '0;
        prev_req        = 1'b0;
        for (int i = 0; i < N; i++) done_cnt[i] = 0;

        test_reset();
        test_single_read();
        test_contention();
        test_rr_wrap();
        test_back_to_back();
        test_overflow();
        test_ack_valid_same();
        test_reset_mid_read();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
